// File: rtl/ped_if.sv
// Crosswalk request bus: raw button and controller lamps in, go/WAIT lamp out.
// The slave side is the request front end. The master side is whatever drives the lamps.
interface ped_if;
  logic btn;
  logic tg;
  logic pg;
  logic go;
  logic wait_lamp;

  modport master (
    output btn, tg, pg,
    input  go, wait_lamp
  );

  modport slave (
    input  btn, tg, pg,
    output go, wait_lamp
  );
endinterface

// File: rtl/ped_request.sv
// Pedestrian request front end: synchronize and debounce the button, hold off go until
// traffic has had its minimum green time, then follow the controller lamps to close out.
module ped_request #(
  parameter int DEBOUNCE_CYCLES  = 1000000,
  parameter int MIN_GREEN_CYCLES = 500000000
) (
  input  logic  clk,
  input  logic  rst_n,
  ped_if.slave  bus
);

  localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int GR_W = $clog2(MIN_GREEN_CYCLES + 1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [GR_W-1:0] GR_FULL = GR_W'(MIN_GREEN_CYCLES);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PENDING = 2'd1,
    ISSUED  = 2'd2,
    SERVING = 2'd3
  } state_t;

  logic            btn_p0;
  logic            btn_s;
  logic            btn_db;
  logic            btn_db_q;
  logic            press;
  logic [DB_W-1:0] db_cnt;
  logic [GR_W-1:0] green_cnt;
  logic            green_ok;

  state_t state, state_nxt;
  logic   rearm, rearm_nxt;
  logic   pg_done, pg_done_nxt;
  logic   pg_seen, pg_seen_nxt;
  logic   pg_q;
  logic   go_r, go_nxt;
  logic   wait_r, wait_nxt;

  // Stage p0/p1: two-flop synchronizer, then debounce and a one-cycle press pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_p0   <= 1'b0;
      btn_s    <= 1'b0;
      btn_db   <= 1'b0;
      btn_db_q <= 1'b0;
      press    <= 1'b0;
      db_cnt   <= '0;
    end else begin
      btn_p0   <= bus.btn;
      btn_s    <= btn_p0;
      if (btn_s == btn_db) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
        btn_db <= btn_s;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
      btn_db_q <= btn_db;
      press    <= btn_db & ~btn_db_q;
    end
  end

  // Green timer saturates so a long green never wraps back below the threshold
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      green_cnt <= '0;
    end else if (!bus.tg) begin
      green_cnt <= '0;
    end else if (green_cnt != GR_FULL) begin
      green_cnt <= green_cnt + 1'b1;
    end
  end

  assign green_ok = (green_cnt == GR_FULL);

  // Request FSM and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      rearm   <= 1'b0;
      pg_done <= 1'b0;
      pg_seen <= 1'b0;
      pg_q    <= 1'b0;
      go_r    <= 1'b0;
      wait_r  <= 1'b0;
    end else begin
      state   <= state_nxt;
      rearm   <= rearm_nxt;
      pg_done <= pg_done_nxt;
      pg_seen <= pg_seen_nxt;
      pg_q    <= bus.pg;
      go_r    <= go_nxt;
      wait_r  <= wait_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    rearm_nxt   = rearm;
    pg_done_nxt = pg_done;
    pg_seen_nxt = pg_seen;
    case (state)
      IDLE:    if (press) state_nxt = PENDING;
      PENDING: if (bus.tg && green_ok) state_nxt = ISSUED;
      ISSUED:  if (!bus.tg) state_nxt = SERVING;
      SERVING: begin
        if (bus.tg) begin
          state_nxt = rearm ? PENDING : IDLE;
        end else begin
          if (pg_q && !bus.pg) pg_done_nxt = 1'b1;
          if (bus.pg)          pg_seen_nxt = 1'b1;
          if (press && pg_done) rearm_nxt  = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase

    // Serving bookkeeping only lives while serving; presses elsewhere are absorbed
    if (state_nxt != SERVING) begin
      rearm_nxt   = 1'b0;
      pg_done_nxt = 1'b0;
      pg_seen_nxt = 1'b0;
    end

    go_nxt   = (state_nxt == ISSUED);
    wait_nxt = (state_nxt == PENDING) || (state_nxt == ISSUED) ||
               ((state_nxt == SERVING) && (rearm_nxt || !pg_seen_nxt));
  end

  assign bus.go        = go_r;
  assign bus.wait_lamp = wait_r;

endmodule

// File: tb/tb_ped_request.sv
// Scoreboard bench for ped_request with short debounce (4) and min-green (10) timing.
module tb_ped_request;

  localparam int SIG_WL    = 0;
  localparam int SIG_GO    = 1;
  localparam int SIG_GOLOW = 2;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;
  int   go_rises;
  logic go_prev;

  string tag_q[$];
  int    val_q[$];

  ped_if bus ();

  ped_request #(
    .DEBOUNCE_CYCLES (4),
    .MIN_GREEN_CYCLES(10)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    go_rises = 0;
    go_prev  = 1'b0;
  end

  always @(negedge clk) begin
    if (bus.go && !go_prev) go_rises++;
    go_prev = bus.go;
  end

  task automatic chk(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic sb_push(input string tag, input int val);
    tag_q.push_back(tag);
    val_q.push_back(val);
  endtask

  task automatic sb_check(input int obs);
    string t;
    int    e;
    if (tag_q.size() == 0) begin
      t = "sb_underflow";
      e = -1;
    end else begin
      t = tag_q.pop_front();
      e = val_q.pop_front();
    end
    chk(t, obs, e);
  endtask

  function automatic logic sig(input int which);
    case (which)
      SIG_WL:    return bus.wait_lamp;
      SIG_GO:    return bus.go;
      SIG_GOLOW: return !bus.go;
      default:   return 1'b0;
    endcase
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Edges counted from the call until the chosen condition holds; -1 on timeout
  task automatic wait_edges(input int which, input int max, output int n);
    n = -1;
    for (int i = 1; i <= max; i++) begin
      @(posedge clk);
      #1;
      if (sig(which)) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic ctrl_cycle();
    bus.tg = 1'b0;
    step(2);
    bus.pg = 1'b1;
    step(3);
    bus.pg = 1'b0;
    step(2);
    bus.tg = 1'b1;
    step(3);
  endtask

  initial begin
    int n;
    int g0;
    logic wl_any;
    logic go_any;
    logic wl_drop;
    int   t_go;

    n_tests = 0;
    n_fail  = 0;
    bus.btn = 1'b0;
    bus.tg  = 1'b0;
    bus.pg  = 1'b0;
    rst_n   = 1'b1;
    #1 rst_n = 1'b0;

    // Reset state
    sb_push("rst_go", 0);
    sb_push("rst_wl", 0);
    step(3);
    sb_check(bus.go);
    sb_check(bus.wait_lamp);
    rst_n = 1'b1;
    step(2);

    // Bounce rejection
    wl_any = 1'b0;
    go_any = 1'b0;
    sb_push("bounce_wl", 0);
    sb_push("bounce_go", 0);
    for (int i = 0; i < 40; i++) begin
      if (i % 2 == 0) bus.btn = ~bus.btn;
      step(1);
      wl_any |= bus.wait_lamp;
      go_any |= bus.go;
    end
    bus.btn = 1'b0;
    for (int i = 0; i < 15; i++) begin
      step(1);
      wl_any |= bus.wait_lamp;
      go_any |= bus.go;
    end
    sb_check(int'(wl_any));
    sb_check(int'(go_any));

    // Clean press on a long green
    bus.tg = 1'b1;
    step(100);
    bus.btn = 1'b1;
    sb_push("clean_wl_lat", 8);
    wait_edges(SIG_WL, 12, n);
    sb_check(n);
    bus.btn = 1'b0;
    sb_push("clean_go_lat", 1);
    wait_edges(SIG_GO, 5, n);
    sb_check(n);
    sb_push("clean_go_hold", 1);
    step(5);
    sb_check(bus.go);
    bus.tg = 1'b0;
    sb_push("clean_go_fall", 1);
    wait_edges(SIG_GOLOW, 5, n);
    sb_check(n);
    sb_push("serving_wl", 1);
    sb_check(bus.wait_lamp);
    bus.pg = 1'b1;
    step(3);
    bus.pg = 1'b0;
    step(2);
    bus.tg = 1'b1;
    step(3);
    sb_push("clean_idle_wl", 0);
    sb_check(bus.wait_lamp);

    // Min-green hold-off: press lands 3 cycles into a fresh green
    bus.tg = 1'b0;
    step(3);
    bus.btn = 1'b1;
    step(4);
    bus.tg  = 1'b1;
    wl_drop = 1'b0;
    t_go    = -1;
    sb_push("mingreen_go_lat", 11);
    sb_push("mingreen_wl_hold", 0);
    for (int i = 1; i <= 20; i++) begin
      step(1);
      if (i == 5) bus.btn = 1'b0;
      if (i >= 4 && !bus.wait_lamp) wl_drop = 1'b1;
      if (bus.go) begin
        t_go = i;
        break;
      end
    end
    sb_check(t_go);
    sb_check(int'(wl_drop));

    // Serving close-out, press absorbed during pg, rearm after pg falls
    bus.tg = 1'b0;
    step(1);
    bus.btn = 1'b1;
    wl_any  = 1'b0;
    sb_push("serve_wl_before_pg", 1);
    sb_push("serve_wl_fall_on_pg", 0);
    sb_push("serve_press_ignored", 0);
    for (int i = 1; i <= 20; i++) begin
      step(1);
      if (i == 4) begin
        sb_check(bus.wait_lamp);
        bus.pg = 1'b1;
      end
      if (i == 5) sb_check(bus.wait_lamp);
      if (i == 6) bus.btn = 1'b0;
      if (i == 9) bus.pg = 1'b0;
      if (i >= 5) wl_any |= bus.wait_lamp;
    end
    sb_check(int'(wl_any));
    bus.btn = 1'b1;
    sb_push("rearm_wl_lat", 8);
    wait_edges(SIG_WL, 12, n);
    sb_check(n);
    bus.btn = 1'b0;
    step(10);
    bus.tg = 1'b1;
    sb_push("rearm_go_lat", 11);
    wait_edges(SIG_GO, 20, n);
    sb_check(n);
    step(2);
    ctrl_cycle();
    sb_push("rearm_idle_wl", 0);
    sb_check(bus.wait_lamp);

    // Held button across a full controller cycle
    step(5);
    g0     = go_rises;
    t_go   = -1;
    bus.btn = 1'b1;
    for (int i = 1; i <= 200; i++) begin
      step(1);
      if (bus.go && t_go < 0) begin
        t_go   = i;
        bus.tg = 1'b0;
      end
      if (t_go > 0) begin
        if (i == t_go + 3) bus.pg = 1'b1;
        if (i == t_go + 6) bus.pg = 1'b0;
        if (i == t_go + 8) bus.tg = 1'b1;
      end
    end
    bus.btn = 1'b0;
    step(20);
    sb_push("held_go_count", 1);
    sb_push("held_idle_wl", 0);
    sb_check(go_rises - g0);
    sb_check(bus.wait_lamp);

    // Reset mid-request with the button still held
    bus.btn = 1'b1;
    sb_push("pre_rst_go_lat", 9);
    wait_edges(SIG_GO, 20, n);
    sb_check(n);
    #3 rst_n = 1'b0;
    #1;
    sb_push("async_rst_go", 0);
    sb_push("async_rst_wl", 0);
    sb_check(bus.go);
    sb_check(bus.wait_lamp);
    step(2);
    rst_n = 1'b1;
    g0    = go_rises;
    sb_push("post_rst_wl_lat", 8);
    wait_edges(SIG_WL, 12, n);
    sb_check(n);
    sb_push("post_rst_go_lat", 3);
    wait_edges(SIG_GO, 12, n);
    sb_check(n);
    ctrl_cycle();
    step(30);
    bus.btn = 1'b0;
    step(20);
    sb_push("post_rst_go_count", 1);
    sb_check(go_rises - g0);

    chk("sb_drained", tag_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

endmodule
